// File: rtl/nfc_pkg.sv
// nfc_pkg: shared definitions for the NFC command sequencer.
//   - cmd word layout: {rw, faddr[17:0], maddr[6:0], len[6:0]}
//   - sequencer FSM state type
//   - request length check and cmd packing helpers
package nfc_pkg;

   localparam int CMD_W     = 33;
   localparam int RW_BIT    = 32;
   localparam int FADDR_MSB = 31;
   localparam int FADDR_LSB = 14;
   localparam int MADDR_MSB = 13;
   localparam int MADDR_LSB = 7;
   localparam int LEN_MSB   = 6;
   localparam int LEN_LSB   = 0;
   localparam int MAX_LEN   = 128;

   typedef enum logic [1:0] {
      S_HOLD   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2,
      S_ERR    = 2'd3
   } nfc_state_t;

   typedef struct packed {
      logic        rw;
      logic [17:0] faddr;
      logic [6:0]  maddr;
      logic [6:0]  len;
   } nfc_cmd_t;

   function automatic logic len_ok(input logic [7:0] len);
      return (len != 8'd0) && (len <= 8'(MAX_LEN));
   endfunction

   // A length of 128 has no 7-bit representation; it is carried as 0.
   function automatic nfc_cmd_t pack_cmd(input logic        rw,
                                         input logic [17:0] faddr,
                                         input logic [6:0]  maddr,
                                         input logic [6:0]  len7);
      logic [CMD_W-1:0] w;
      w                        = '0;
      w[RW_BIT]                = rw;
      w[FADDR_MSB:FADDR_LSB]   = faddr;
      w[MADDR_MSB:MADDR_LSB]   = maddr;
      w[LEN_MSB:LEN_LSB]       = len7;
      return nfc_cmd_t'(w);
   endfunction

endpackage

// File: rtl/nfc_req_fifo.sv
// nfc_req_fifo: synchronous request FIFO, show-ahead read (dout is the head).
//   clk, rst (async, active low)
//   push/din  : write, ignored when full
//   pop/dout  : read, ignored when empty
//   full, empty, count (0..DEPTH)
module nfc_req_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/nfc_cmd_sequencer.sv
// nfc_cmd_sequencer: queues host transfer requests and feeds them to the NFC,
// owning the NFC reset so the NFC only runs while there is work.
//   host side : req_valid/req_ready, req_rw, req_faddr, req_maddr, req_len, bad_len
//   NFC side  : nfc_cmd, nfc_rst (active high), nfc_done
//   status    : cmp_valid, cmp_rw, busy, err, err_clr
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_HOLD   | NFC held in reset, waiting for a queued request
// S_LAUNCH | reset released, waiting for NFC's first done (RST->IDLE)
// S_RUN    | cmd held until done; done completes it and loads the next
// S_ERR    | watchdog fired, NFC held in reset until err_clr
module nfc_cmd_sequencer
   import nfc_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_rw,
   input  logic [17:0]      req_faddr,
   input  logic [6:0]       req_maddr,
   input  logic [7:0]       req_len,
   output logic             bad_len,
   output logic [CMD_W-1:0] nfc_cmd,
   output logic             nfc_rst,
   input  logic             nfc_done,
   output logic             cmp_valid,
   output logic             cmp_rw,
   output logic             busy,
   output logic             err,
   input  logic             err_clr
);
   localparam int              CW      = $clog2(DEPTH) + 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   nfc_state_t       state;
   nfc_cmd_t         cmd_q;
   logic [TO_W-1:0]  wd_cnt;
   logic [CMD_W-1:0] req_word;
   logic [CMD_W-1:0] fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CW-1:0]    fifo_count;
   logic [CW-1:0]    cnt_nxt;
   logic             accept;
   logic             push;
   logic             pop;

   assign req_ready = !fifo_full;
   assign accept    = req_valid && req_ready;
   assign push      = accept && len_ok(req_len);
   assign pop       = !fifo_empty &&
                      ((state == S_HOLD) || (state == S_RUN && nfc_done));
   // FIFO occupancy after this edge; busy is registered from it.
   assign cnt_nxt   = fifo_count + CW'(push) - CW'(pop);
   assign req_word  = pack_cmd(req_rw, req_faddr, req_maddr, req_len[LEN_MSB:0]);
   assign nfc_cmd   = cmd_q;

   nfc_req_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (req_word),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_HOLD;
         cmd_q     <= '0;
         nfc_rst   <= 1'b1;
         bad_len   <= 1'b0;
         cmp_valid <= 1'b0;
         cmp_rw    <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         wd_cnt    <= '0;
      end else begin
         bad_len   <= accept && !len_ok(req_len);
         cmp_valid <= 1'b0;
         busy      <= 1'b1;
         case (state)
            S_HOLD: begin
               wd_cnt <= '0;
               if (!fifo_empty) begin
                  cmd_q   <= nfc_cmd_t'(fifo_dout);
                  nfc_rst <= 1'b0;
                  state   <= S_LAUNCH;
               end else begin
                  busy <= (cnt_nxt != '0);
               end
            end
            S_LAUNCH, S_RUN: begin
               if (nfc_done) begin
                  wd_cnt <= '0;
                  if (state == S_LAUNCH) begin
                     state <= S_RUN;
                  end else begin
                     cmp_valid <= 1'b1;
                     cmp_rw    <= cmd_q.rw;
                     // The NFC samples cmd one cycle later in WAIT_CMD.
                     if (!fifo_empty) begin
                        cmd_q <= nfc_cmd_t'(fifo_dout);
                     end else begin
                        nfc_rst <= 1'b1;
                        state   <= S_HOLD;
                        busy    <= (cnt_nxt != '0);
                     end
                  end
               end else if (wd_cnt == TO_LAST) begin
                  wd_cnt  <= '0;
                  err     <= 1'b1;
                  nfc_rst <= 1'b1;
                  state   <= S_ERR;
               end else begin
                  wd_cnt <= wd_cnt + TO_W'(1);
               end
            end
            S_ERR: begin
               nfc_rst <= 1'b1;
               if (err_clr) begin
                  err   <= 1'b0;
                  state <= S_HOLD;
                  busy  <= (cnt_nxt != '0);
               end
            end
            default: state <= S_HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_nfc_cmd_sequencer.sv
// tb_nfc_cmd_sequencer: directed sequence with randomized request fields,
// checked against a queue model of the request FIFO and an arithmetic
// model of the cmd encoding. The bench plays the NFC by driving nfc_done.
module tb_nfc_cmd_sequencer;
   localparam int DEPTH   = 4;
   localparam int TO_W    = 16;
   localparam int TIMEOUT = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_rw;
   logic [17:0] req_faddr;
   logic [6:0]  req_maddr;
   logic [7:0]  req_len;
   logic        bad_len;
   logic [32:0] nfc_cmd;
   logic        nfc_rst;
   logic        nfc_done;
   logic        cmp_valid;
   logic        cmp_rw;
   logic        busy;
   logic        err;
   logic        err_clr;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [32:0] mq[$];
   logic [32:0] cur;

   nfc_cmd_sequencer #(
      .DEPTH   (DEPTH),
      .TO_W    (TO_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rw    (req_rw),
      .req_faddr (req_faddr),
      .req_maddr (req_maddr),
      .req_len   (req_len),
      .bad_len   (bad_len),
      .nfc_cmd   (nfc_cmd),
      .nfc_rst   (nfc_rst),
      .nfc_done  (nfc_done),
      .cmp_valid (cmp_valid),
      .cmp_rw    (cmp_rw),
      .busy      (busy),
      .err       (err),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   function automatic logic [32:0] enc(input logic rw, input logic [17:0] fa,
                                       input logic [6:0] ma, input logic [7:0] len);
      longint v;
      v = longint'(rw) * 64'h1_0000_0000 + longint'(fa) * 16384 +
          longint'(ma) * 128 + longint'(len % 8'd128);
      return v[32:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic [7:0] len);
      req_rw    = 1'($urandom);
      req_faddr = 18'($urandom);
      req_maddr = 7'($urandom);
      req_len   = len;
   endtask

   // One clock: check ready against the model, then update the model queue.
   task automatic cyc(input bit pop_now);
      bit          exp_ready;
      bit          acc;
      logic [32:0] word;
      exp_ready = (mq.size() < DEPTH);
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      acc  = req_valid && exp_ready && (req_len != 8'd0) && (req_len <= 8'd128);
      word = enc(req_rw, req_faddr, req_maddr, req_len);
      @(posedge clk);
      #1;
      if (pop_now) begin
         n_chk++;
         assert (mq.size() != 0) else begin
            n_fail++;
            $error("FAIL model_pop observed=empty expected=entry");
         end
         if (mq.size() != 0) cur = mq.pop_front();
      end
      if (acc) mq.push_back(word);
   endtask

   // Consecutive pushes from idle; the second edge loads the first entry.
   task automatic push_n(input int n, input bit last128);
      for (int i = 0; i < n; i++) begin
         set_req((last128 && i == n - 1) ? 8'd128 : 8'($urandom_range(1, 128)));
         req_valid = 1'b1;
         cyc(i == 1);
      end
      req_valid = 1'b0;
      if (n == 1) cyc(1'b1);
   endtask

   task automatic launch();
      chk("launch_cmd", 64'(nfc_cmd), 64'(cur));
      chk("launch_rst", 64'(nfc_rst), 64'd0);
      cyc(1'b0);
      nfc_done = 1'b1;
      cyc(1'b0);
      nfc_done = 1'b0;
      chk("launch_no_cmp", 64'(cmp_valid), 64'd0);
   endtask

   task automatic drain_run();
      bit   last;
      logic exp_rw;
      for (int k = 0; k < 2 * DEPTH + 2; k++) begin
         repeat ($urandom_range(0, 4)) cyc(1'b0);
         chk("run_rst_low", 64'(nfc_rst), 64'd0);
         exp_rw   = cur[32];
         last     = (mq.size() == 0);
         nfc_done = 1'b1;
         cyc(!last);
         nfc_done = 1'b0;
         chk("cmp_valid", 64'(cmp_valid), 64'd1);
         chk("cmp_rw", 64'(cmp_rw), 64'(exp_rw));
         if (last) begin
            chk("hold_rst_high", 64'(nfc_rst), 64'd1);
            break;
         end
         chk("next_cmd", 64'(nfc_cmd), 64'(cur));
      end
      cyc(1'b0);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_cmp", 64'(cmp_valid), 64'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL sim_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_faddr = '0;
      req_maddr = '0; req_len = '0; nfc_done = 1'b0; err_clr = 1'b0;
      cur = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_nfc_rst", 64'(nfc_rst), 64'd1);
      chk("rst_nfc_cmd", 64'(nfc_cmd), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_bad_len", 64'(bad_len), 64'd0);
      chk("rst_cmp_valid", 64'(cmp_valid), 64'd0);
      chk("rst_cmp_rw", 64'(cmp_rw), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rst = 1'b1;

      // Single read request with the documented encoding.
      req_rw = 1'b1; req_faddr = 18'h00105; req_maddr = 7'd3; req_len = 8'd10;
      req_valid = 1'b1;
      cyc(1'b0);
      req_valid = 1'b0;
      chk("single_busy", 64'(busy), 64'd1);
      chk("single_rst_before", 64'(nfc_rst), 64'd1);
      cyc(1'b1);
      chk("single_cmd_const", 64'(nfc_cmd), 64'h1_0041_418A);
      launch();
      drain_run();

      // Back-to-back, last one len=128.
      push_n(3, 1'b1);
      launch();
      drain_run();

      // Illegal lengths are accepted and dropped.
      set_req(8'd0);
      req_valid = 1'b1;
      cyc(1'b0);
      chk("bad_len_0", 64'(bad_len), 64'd1);
      req_len = 8'd200;
      cyc(1'b0);
      chk("bad_len_200", 64'(bad_len), 64'd1);
      req_valid = 1'b0;
      cyc(1'b0);
      chk("bad_len_clear", 64'(bad_len), 64'd0);
      chk("bad_len_busy", 64'(busy), 64'd0);
      chk("bad_len_cmd", 64'(nfc_cmd), 64'(cur));
      chk("bad_len_rst", 64'(nfc_rst), 64'd1);

      // Full FIFO: extra request waits; pop+push on full refuses the push.
      push_n(DEPTH + 1, 1'b0);
      set_req(8'($urandom_range(1, 128)));
      req_valid = 1'b1;
      chk("full_ready", 64'(req_ready), 64'd0);
      repeat (3) cyc(1'b0);
      nfc_done = 1'b1;
      cyc(1'b0);
      chk("full_launch_no_cmp", 64'(cmp_valid), 64'd0);
      cyc(1'b1);
      nfc_done = 1'b0;
      chk("full_pop_cmp", 64'(cmp_valid), 64'd1);
      chk("full_pop_cmd", 64'(nfc_cmd), 64'(cur));
      cyc(1'b0);
      req_valid = 1'b0;
      drain_run();

      // Watchdog: withhold done in S_RUN.
      push_n(3, 1'b0);
      launch();
      for (int t = 1; t < TIMEOUT; t++) cyc(1'b0);
      chk("wd_err_before", 64'(err), 64'd0);
      cyc(1'b0);
      chk("wd_err", 64'(err), 64'd1);
      chk("wd_nfc_rst", 64'(nfc_rst), 64'd1);
      set_req(8'($urandom_range(1, 128)));
      req_valid = 1'b1;
      cyc(1'b0);
      req_valid = 1'b0;
      nfc_done = 1'b1;
      cyc(1'b0);
      nfc_done = 1'b0;
      chk("err_done_ignored", 64'(cmp_valid), 64'd0);
      chk("err_sticky", 64'(err), 64'd1);
      err_clr = 1'b1;
      cyc(1'b0);
      err_clr = 1'b0;
      chk("err_clr", 64'(err), 64'd0);
      chk("err_clr_rst", 64'(nfc_rst), 64'd1);
      cyc(1'b1);
      launch();
      drain_run();

      // Random rounds.
      repeat (4) begin
         push_n($urandom_range(1, DEPTH), 1'b0);
         launch();
         drain_run();
      end

      // Async reset in the middle of S_RUN.
      push_n(2, 1'b0);
      launch();
      cyc(1'b0);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_nfc_rst", 64'(nfc_rst), 64'd1);
      chk("arst_nfc_cmd", 64'(nfc_cmd), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_ready", 64'(req_ready), 64'd1);
      chk("arst_err", 64'(err), 64'd0);
      mq.delete();
      #2;
      rst = 1'b1;
      cyc(1'b0);
      chk("arst_after_rst", 64'(nfc_rst), 64'd1);
      chk("arst_after_busy", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
